// File: rtl/uart_pkg.sv
// uart_pkg: FSM state encoding and default frame parameters shared by the UART blocks
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;
  localparam int OVERSAMPLE_DEF = 16;
  localparam int DATA_BITS_DEF  = 8;
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchronizer for the serial line, resets to the idle-high level
//   Clk   - system clock
//   Rst_n - asynchronous active-low reset
//   d     - asynchronous input
//   q     - synchronized output
module uart_rx_sync (
  input  logic Clk,
  input  logic Rst_n,
  input  logic d,
  output logic q
);
  logic s1;
  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) {q, s1} <= 2'b11;
    else        {q, s1} <= {s1, d};
endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver, 1 start bit, DATA_BITS data bits LSB first, 1 stop bit
//   Clk      - system clock
//   Rst_n    - asynchronous active-low reset
//   Tick     - one-cycle strobe at OVERSAMPLE x baud
//   Rx       - serial line, idle high
//   DataOut  - last correctly framed word
//   RxDone   - one-cycle pulse when DataOut is updated
//   FrameErr - one-cycle pulse when the stop bit samples low
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DATA_BITS_DEF,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic                 Tick,
  input  logic                 Rx,
  output logic [DATA_BITS-1:0] DataOut,
  output logic                 RxDone,
  output logic                 FrameErr
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);
  uart_state_e state, state_nx;
  logic [TW-1:0] tick_cnt, tick_nx;
  logic [2:0] bit_cnt, bit_nx;
  logic [DATA_BITS-1:0] shreg, shreg_nx, data_nx;
  logic done_nx, err_nx;
  logic rx_s, rx_prev, fall, edge_pend;
  uart_rx_sync u_sync (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .d     (Rx),
    .q     (rx_s)
  );
  assign fall = rx_prev & ~rx_s;
  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      DataOut   <= '0;
      RxDone    <= 1'b0;
      FrameErr  <= 1'b0;
      rx_prev   <= 1'b1;
      edge_pend <= 1'b0;
    end else begin
      state     <= state_nx;
      tick_cnt  <= tick_nx;
      bit_cnt   <= bit_nx;
      shreg     <= shreg_nx;
      DataOut   <= data_nx;
      RxDone    <= done_nx;
      FrameErr  <= err_nx;
      rx_prev   <= rx_s;
      // an edge seen while leaving STOP would otherwise be lost, so carry it into IDLE
      edge_pend <= (state == STOP) && (state_nx == IDLE) && fall;
    end
  always_comb begin
    state_nx = state;
    tick_nx  = tick_cnt;
    bit_nx   = bit_cnt;
    shreg_nx = shreg;
    data_nx  = DataOut;
    done_nx  = 1'b0;
    err_nx   = 1'b0;
    case (state)
      IDLE:
        if (fall || edge_pend) begin
          state_nx = START;
          tick_nx  = '0;
        end
      START:
        if (Tick) begin
          tick_nx = tick_cnt + 1'b1;
          if (tick_cnt == HALF) begin
            state_nx = rx_s ? IDLE : DATA;
            tick_nx  = '0;
            bit_nx   = '0;
          end
        end
      DATA:
        if (Tick) begin
          tick_nx = tick_cnt + 1'b1;
          if (tick_cnt == LAST) begin
            shreg_nx = {rx_s, shreg[DATA_BITS-1:1]};
            bit_nx   = bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) begin
              state_nx = STOP;
              bit_nx   = '0;
            end
          end
        end
      STOP:
        if (Tick) begin
          tick_nx = tick_cnt + 1'b1;
          if (tick_cnt == LAST) begin
            state_nx = IDLE;
            data_nx  = rx_s ? shreg : DataOut;
            done_nx  = rx_s;
            err_nx   = ~rx_s;
          end
        end
      default: state_nx = IDLE;
    endcase
  end
endmodule
